// File: rtl/mem_io_router.sv
// Registered MEM-stage router: decodes each Load/Store once, then steers it to the
// L1 D$, the internal timer/MSIP block, or one of N_EXT external I/O channels.
module mem_io_router #(
    parameter int              AW           = 32,
    parameter int              DW           = 32,
    parameter logic [AW-1:0]   PHY_LO       = 32'h0000_0000,
    parameter logic [AW-1:0]   PHY_HI       = 32'h0FFF_FFFF,
    parameter logic [AW-1:0]   INT_BASE     = 32'hFFFF_0000,
    parameter logic [AW-1:0]   EXT_LO       = 32'hF000_0000,
    parameter int              EXT_WIN_LOG2 = 12,
    parameter int              N_EXT        = 4,
    parameter int              TMO_CYC      = 64
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [1:0]            mode,
    input  logic                  req,
    input  logic [AW-1:0]         req_addr,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [DW-1:0]         req_wr_data,
    output logic                  ack,
    output logic [DW-1:0]         ack_data,
    output logic                  ack_fault,
    output logic [1:0]            fault_code,
    output logic                  dc_req,
    output logic [AW-1:0]         dc_addr,
    output logic                  dc_rd,
    output logic                  dc_wr,
    output logic [DW-1:0]         dc_wr_data,
    input  logic                  dc_ack,
    input  logic [DW-1:0]         dc_ack_data,
    input  logic                  dc_ack_fault,
    output logic [4:0]            mmr_wr,
    output logic [DW-1:0]         mmr_wr_data,
    input  logic [2*DW-1:0]       mtime,
    input  logic [2*DW-1:0]       mtimecmp,
    input  logic [DW-1:0]         msip_reg,
    output logic [N_EXT-1:0]      io_req,
    output logic [AW-1:0]         io_addr,
    output logic                  io_rd,
    output logic                  io_wr,
    output logic [DW-1:0]         io_wr_data,
    input  logic [N_EXT*DW-1:0]   io_rd_data,
    input  logic [N_EXT-1:0]      io_ack,
    input  logic [N_EXT-1:0]      io_ack_fault
);

    localparam int TW = $clog2(TMO_CYC + 1);

    localparam logic [1:0] FC_NONE   = 2'd0;
    localparam logic [1:0] FC_DECODE = 2'd1;
    localparam logic [1:0] FC_PRIV   = 2'd2;
    localparam logic [1:0] FC_BUS    = 2'd3;

    typedef enum logic [1:0] {IDLE, DC_WAIT, EXT_WAIT, RESP} state_t;

    state_t          state_q;
    logic [TW-1:0]   tmo_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            rd_q;

    logic            rw_bad;
    logic            phy_hit;
    logic [AW-1:0]   int_off;
    logic            int_hit;
    logic [AW-1:0]   ext_off;
    logic [AW-1:0]   ext_idx;
    logic            ext_hit;
    logic [N_EXT-1:0] ext_onehot;
    logic [4:0]      mmr_strobe;
    logic [DW-1:0]   int_rdata;
    logic [DW-1:0]   io_sel_data;
    logic            io_sel_ack;
    logic            io_sel_flt;
    logic            tmo_hit;

    assign rw_bad     = (req_rd == req_wr);
    assign phy_hit    = (req_addr >= PHY_LO) && (req_addr <= PHY_HI);
    assign int_off    = req_addr - INT_BASE;
    assign int_hit    = (int_off[AW-1:5] == '0) && (int_off[1:0] == 2'b00) && (int_off[4:2] <= 3'd4);
    assign ext_off    = req_addr - EXT_LO;
    assign ext_idx    = ext_off >> EXT_WIN_LOG2;
    assign ext_hit    = (req_addr >= EXT_LO) && (ext_idx < AW'(N_EXT));
    assign ext_onehot = N_EXT'(1) << ext_idx[3:0];
    assign mmr_strobe = 5'd1 << int_off[4:2];
    assign tmo_hit    = (tmo_q == TW'(TMO_CYC - 1));

    always_comb begin
        case (int_off[4:2])
            3'd0:    int_rdata = mtime[DW-1:0];
            3'd1:    int_rdata = mtime[2*DW-1:DW];
            3'd2:    int_rdata = mtimecmp[DW-1:0];
            3'd3:    int_rdata = mtimecmp[2*DW-1:DW];
            default: int_rdata = msip_reg;
        endcase
    end

    // io_req is one-hot on the selected channel while waiting, so it doubles as the response mask.
    always_comb begin
        io_sel_data = '0;
        for (int k = 0; k < N_EXT; k++) begin
            if (io_req[k]) io_sel_data = io_sel_data | io_rd_data[k*DW +: DW];
        end
    end
    assign io_sel_ack = |(io_ack & io_req);
    assign io_sel_flt = |(io_ack_fault & io_req);

    assign dc_addr     = addr_q;
    assign io_addr     = addr_q;
    assign dc_wr_data  = wdata_q;
    assign io_wr_data  = wdata_q;
    assign mmr_wr_data = wdata_q;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            ack        <= 1'b0;
            ack_data   <= '0;
            ack_fault  <= 1'b0;
            fault_code <= FC_NONE;
            dc_req     <= 1'b0;
            dc_rd      <= 1'b0;
            dc_wr      <= 1'b0;
            mmr_wr     <= '0;
            io_req     <= '0;
            io_rd      <= 1'b0;
            io_wr      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wr_data;
                        rd_q    <= req_rd;
                        if (rw_bad) begin
                            ack        <= 1'b1;
                            ack_fault  <= 1'b1;
                            fault_code <= FC_DECODE;
                            state_q    <= RESP;
                        end else if (phy_hit) begin
                            dc_req  <= 1'b1;
                            dc_rd   <= req_rd;
                            dc_wr   <= req_wr;
                            state_q <= DC_WAIT;
                        end else if (int_hit) begin
                            ack     <= 1'b1;
                            state_q <= RESP;
                            if (mode != 2'd3) begin
                                ack_fault  <= 1'b1;
                                fault_code <= FC_PRIV;
                            end else begin
                                ack_data <= req_rd ? int_rdata : '0;
                                mmr_wr   <= req_wr ? mmr_strobe : 5'd0;
                            end
                        end else if (ext_hit) begin
                            io_req  <= ext_onehot;
                            io_rd   <= req_rd;
                            io_wr   <= req_wr;
                            state_q <= EXT_WAIT;
                        end else begin
                            ack        <= 1'b1;
                            ack_fault  <= 1'b1;
                            fault_code <= FC_DECODE;
                            state_q    <= RESP;
                        end
                    end
                end
                DC_WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (dc_ack || tmo_hit) begin
                        dc_req  <= 1'b0;
                        dc_rd   <= 1'b0;
                        dc_wr   <= 1'b0;
                        ack     <= 1'b1;
                        state_q <= RESP;
                        // A target ack landing on the timeout cycle takes precedence.
                        if (!dc_ack || dc_ack_fault) begin
                            ack_fault  <= 1'b1;
                            fault_code <= FC_BUS;
                        end else begin
                            ack_data <= rd_q ? dc_ack_data : '0;
                        end
                    end
                end
                EXT_WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (io_sel_ack || io_sel_flt || tmo_hit) begin
                        io_req  <= '0;
                        io_rd   <= 1'b0;
                        io_wr   <= 1'b0;
                        ack     <= 1'b1;
                        state_q <= RESP;
                        if (io_sel_flt || !io_sel_ack) begin
                            ack_fault  <= 1'b1;
                            fault_code <= FC_BUS;
                        end else begin
                            ack_data <= rd_q ? io_sel_data : '0;
                        end
                    end
                end
                RESP: begin
                    ack        <= 1'b0;
                    ack_data   <= '0;
                    ack_fault  <= 1'b0;
                    fault_code <= FC_NONE;
                    mmr_wr     <= '0;
                    tmo_q      <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_router.sv
// Directed bench for mem_io_router: internal regs, D$ path, external channels,
// timeout, decode/privilege faults and mid-transaction reset.
module tb_mem_io_router;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic [1:0]   mode;
    logic         req;
    logic [31:0]  req_addr;
    logic         req_rd;
    logic         req_wr;
    logic [31:0]  req_wr_data;
    logic         ack;
    logic [31:0]  ack_data;
    logic         ack_fault;
    logic [1:0]   fault_code;
    logic         dc_req;
    logic [31:0]  dc_addr;
    logic         dc_rd;
    logic         dc_wr;
    logic [31:0]  dc_wr_data;
    logic         dc_ack;
    logic [31:0]  dc_ack_data;
    logic         dc_ack_fault;
    logic [4:0]   mmr_wr;
    logic [31:0]  mmr_wr_data;
    logic [63:0]  mtime;
    logic [63:0]  mtimecmp;
    logic [31:0]  msip_reg;
    logic [3:0]   io_req;
    logic [31:0]  io_addr;
    logic         io_rd;
    logic         io_wr;
    logic [31:0]  io_wr_data;
    logic [127:0] io_rd_data;
    logic [3:0]   io_ack;
    logic [3:0]   io_ack_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    mem_io_router dut (
        .clk_in(clk_in), .reset_in(reset_in), .mode(mode), .req(req),
        .req_addr(req_addr), .req_rd(req_rd), .req_wr(req_wr), .req_wr_data(req_wr_data),
        .ack(ack), .ack_data(ack_data), .ack_fault(ack_fault), .fault_code(fault_code),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_rd(dc_rd), .dc_wr(dc_wr),
        .dc_wr_data(dc_wr_data), .dc_ack(dc_ack), .dc_ack_data(dc_ack_data),
        .dc_ack_fault(dc_ack_fault), .mmr_wr(mmr_wr), .mmr_wr_data(mmr_wr_data),
        .mtime(mtime), .mtimecmp(mtimecmp), .msip_reg(msip_reg),
        .io_req(io_req), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
        .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .io_ack(io_ack),
        .io_ack_fault(io_ack_fault)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic start_req(input logic [31:0] a, input logic r, input logic w,
                             input logic [31:0] d, input logic [1:0] m);
        req_addr    = a;
        req_rd      = r;
        req_wr      = w;
        req_wr_data = d;
        mode        = m;
        req         = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic end_req();
        req = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        reset_in     = 1'b1;
        mode         = 2'd3;
        req          = 1'b0;
        req_addr     = '0;
        req_rd       = 1'b0;
        req_wr       = 1'b0;
        req_wr_data  = '0;
        dc_ack       = 1'b0;
        dc_ack_data  = '0;
        dc_ack_fault = 1'b0;
        mtime        = 64'hAAAA_BBBB_1111_2222;
        mtimecmp     = 64'h0000_0001_2345_6789;
        msip_reg     = 32'h0000_0001;
        io_rd_data   = '0;
        io_ack       = '0;
        io_ack_fault = '0;

        repeat (3) @(negedge clk_in);
        check("rst_ack", ack, 1'b0);
        check("rst_dc_req", dc_req, 1'b0);
        check("rst_io_req", io_req, 4'b0000);
        check("rst_mmr_wr", mmr_wr, 5'd0);
        check("rst_fault_code", fault_code, 2'd0);
        reset_in = 1'b0;
        @(negedge clk_in);

        // M-mode read of mtimecmp lo
        start_req(32'hFFFF_0008, 1'b1, 1'b0, 32'h0, 2'd3);
        check("int_rd_ack", ack, 1'b1);
        check("int_rd_data", ack_data, 32'h2345_6789);
        check("int_rd_fc", fault_code, 2'd0);
        end_req();
        check("int_rd_ack_drop", ack, 1'b0);

        // U-mode write to mtime lo
        start_req(32'hFFFF_0000, 1'b0, 1'b1, 32'h1234_5678, 2'd0);
        check("priv_ack", ack, 1'b1);
        check("priv_fault", ack_fault, 1'b1);
        check("priv_fc", fault_code, 2'd2);
        check("priv_mmr_wr", mmr_wr, 5'd0);
        end_req();

        // M-mode write to MSIP
        start_req(32'hFFFF_0010, 1'b0, 1'b1, 32'h0000_0001, 2'd3);
        check("msip_wr_strobe", mmr_wr, 5'b10000);
        check("msip_wr_data", mmr_wr_data, 32'h0000_0001);
        check("msip_wr_ackdata", ack_data, 32'h0);
        end_req();
        check("msip_wr_strobe_drop", mmr_wr, 5'd0);

        // D$ read, ack in third dc_req cycle
        start_req(32'h0000_1000, 1'b1, 1'b0, 32'h0, 2'd3);
        check("dc_req_c1", dc_req, 1'b1);
        check("dc_addr", dc_addr, 32'h0000_1000);
        check("dc_rd", dc_rd, 1'b1);
        @(negedge clk_in);
        @(negedge clk_in);
        check("dc_req_c3", dc_req, 1'b1);
        check("dc_ack_not_yet", ack, 1'b0);
        dc_ack      = 1'b1;
        dc_ack_data = 32'hCAFE_F00D;
        @(negedge clk_in);
        dc_ack = 1'b0;
        check("dc_ack", ack, 1'b1);
        check("dc_ack_data", ack_data, 32'hCAFE_F00D);
        check("dc_fc", fault_code, 2'd0);
        check("dc_req_drop", dc_req, 1'b0);
        end_req();

        // rd and wr both set
        start_req(32'h0000_1000, 1'b1, 1'b1, 32'h0, 2'd3);
        check("rw_ack", ack, 1'b1);
        check("rw_fc", fault_code, 2'd1);
        check("rw_dc_req", dc_req, 1'b0);
        end_req();

        // External write on channel 2 with a stray ack on channel 1
        start_req(32'hF000_2004, 1'b0, 1'b1, 32'h5555_AAAA, 2'd3);
        check("ext_io_req", io_req, 4'b0100);
        check("ext_io_addr", io_addr, 32'hF000_2004);
        check("ext_io_wr", io_wr, 1'b1);
        check("ext_wr_data", io_wr_data, 32'h5555_AAAA);
        io_ack = 4'b0010;
        @(negedge clk_in);
        check("ext_stray_ack", ack, 1'b0);
        check("ext_io_req_held", io_req, 4'b0100);
        io_ack = 4'b0100;
        @(negedge clk_in);
        io_ack = 4'b0000;
        check("ext_ack", ack, 1'b1);
        check("ext_fc", fault_code, 2'd0);
        check("ext_wr_ackdata", ack_data, 32'h0);
        end_req();

        // External read, no ack: timeout after 64 wait cycles
        start_req(32'hF000_3000, 1'b1, 1'b0, 32'h0, 2'd3);
        repeat (63) @(negedge clk_in);
        check("tmo_io_req_c64", io_req, 4'b1000);
        check("tmo_ack_c64", ack, 1'b0);
        @(negedge clk_in);
        check("tmo_io_req_drop", io_req, 4'b0000);
        check("tmo_ack", ack, 1'b1);
        check("tmo_fault", ack_fault, 1'b1);
        check("tmo_fc", fault_code, 2'd3);
        end_req();

        // Same, but ack arrives on wait cycle 64
        io_rd_data[3*32 +: 32] = 32'h1234_ABCD;
        start_req(32'hF000_3000, 1'b1, 1'b0, 32'h0, 2'd3);
        repeat (63) @(negedge clk_in);
        io_ack = 4'b1000;
        @(negedge clk_in);
        io_ack = 4'b0000;
        check("tmo_race_ack", ack, 1'b1);
        check("tmo_race_fault", ack_fault, 1'b0);
        check("tmo_race_data", ack_data, 32'h1234_ABCD);
        end_req();

        // Channel 5 is beyond N_EXT
        start_req(32'hF000_5000, 1'b1, 1'b0, 32'h0, 2'd3);
        check("ch5_fc", fault_code, 2'd1);
        check("ch5_io_req", io_req, 4'b0000);
        end_req();

        // Reset during EXT_WAIT
        start_req(32'hF000_1000, 1'b1, 1'b0, 32'h0, 2'd3);
        check("rst_mid_io_req_before", io_req, 4'b0010);
        #2 reset_in = 1'b1;
        #1;
        check("rst_mid_io_req", io_req, 4'b0000);
        check("rst_mid_ack", ack, 1'b0);
        req = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        start_req(32'hFFFF_0004, 1'b1, 1'b0, 32'h0, 2'd3);
        check("post_rst_ack", ack, 1'b1);
        check("post_rst_data", ack_data, 32'hAAAA_BBBB);
        end_req();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
